// File: rtl/eth_rt_tx_sink_if.sv
// rtl/eth_rt_tx_sink_if.sv - GMII-style Tx byte stream in, buffered payload byte stream out
interface eth_rt_tx_sink_if;
    logic       TxEn;
    logic       DataReady;
    logic [7:0] TxD;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_eof;
    logic       out_err;

    modport master (
        output TxEn, DataReady, TxD, out_ready,
        input  out_valid, out_data, out_eof, out_err
    );

    modport slave (
        input  TxEn, DataReady, TxD, out_ready,
        output out_valid, out_data, out_eof, out_err
    );
endinterface

// File: rtl/eth_rt_tx_sink.sv
// rtl/eth_rt_tx_sink.sv - preamble strip, FCS check, length check and payload FIFO for the RT Ethernet Tx stream
// Optional frame statistics counters readable on reg_rdata_o when ETH_TX_SINK_STATS_EN is defined.
module eth_rt_tx_sink #(
    parameter int FIFO_AW   = 4,
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic            clk_i,
    input  logic            resetActive_i,
    input  logic            clearErrors_i,
    eth_rt_tx_sink_if.slave bus,
    output logic            stat_valid_o,
    output logic [11:0]     stat_len_o,
    output logic            stat_crc_err_o,
    output logic            stat_runt_o,
    output logic            stat_over_o,
    output logic            pre_err_o,
    output logic            ovf_err_o,
    input  logic [15:0]     reg_raddr_i,
    output logic [31:0]     reg_rdata_o
);
    localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME);
    localparam logic [11:0] MAX_LEN = 12'(MAX_FRAME);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_FRAME, S_DISCARD} state_t;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // MSB-first CRC-32 fed with the bit-reversed byte, matching the Tx side generator.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic [7:0]  d;
        r = c;
        d = rev8(b);
        for (int i = 7; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04c11db7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        pcnt_q, pcnt_d;
    logic [11:0]       len_q, len_d;
    logic [7:0]        sr_q [5];
    logic [7:0]        sr_d [5];
    logic [2:0]        sr_cnt_q, sr_cnt_d;
    logic [31:0]       crc_q, crc_d;
    logic              frame_ovf_q, frame_ovf_d;
    logic              pre_err_q, pre_err_d;
    logic              ovf_err_q, ovf_err_d;
    logic              stat_valid_q;
    logic [11:0]       stat_len_q;
    logic              stat_crc_q, stat_runt_q, stat_over_q;
    logic [FIFO_AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [9:0]        mem_q [2**FIFO_AW];

    logic              accept;
    logic              pre_set, frame_start, end_frame;
    logic              push, push_eof, push_err;
    logic [7:0]        push_data;
    logic [31:0]       crc_fin;
    logic              fcs_ok, st_short, st_crc, st_runt, st_over;
    logic              fifo_empty, fifo_full, pop, push_ok, drop, overwrite;
    logic [FIFO_AW-1:0] tail_idx;
    logic [9:0]        head;

    assign accept = bus.TxEn & bus.DataReady;

    // At TxEn fall the oldest shift-register byte is the last data byte, the other four are the FCS.
    assign crc_fin  = crc32_byte(crc_q, sr_q[0]);
    assign fcs_ok   = (sr_q[1] == ~rev8(crc_fin[31:24])) && (sr_q[2] == ~rev8(crc_fin[23:16])) &&
                      (sr_q[3] == ~rev8(crc_fin[15:8]))  && (sr_q[4] == ~rev8(crc_fin[7:0]));
    assign st_short = (sr_cnt_q != 3'd5);
    assign st_crc   = st_short | ~fcs_ok;
    assign st_runt  = st_short | (len_q < MIN_LEN);
    assign st_over  = (len_q > MAX_LEN);

    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        len_d       = len_q;
        sr_d        = sr_q;
        sr_cnt_d    = sr_cnt_q;
        crc_d       = crc_q;
        pre_set     = 1'b0;
        frame_start = 1'b0;
        end_frame   = 1'b0;
        push        = 1'b0;
        push_eof    = 1'b0;
        push_err    = 1'b0;
        push_data   = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.TxD == 8'h55) begin
                        state_d = S_PRE;
                        pcnt_d  = 4'd1;
                    end else begin
                        state_d = S_DISCARD;
                        pre_set = 1'b1;
                    end
                end
            end
            S_PRE: begin
                if (!bus.TxEn) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    if (bus.TxD == 8'h55) begin
                        pcnt_d = (pcnt_q == 4'hf) ? pcnt_q : pcnt_q + 4'd1;
                    end else if (bus.TxD == 8'hd5 && pcnt_q == 4'd7) begin
                        state_d     = S_FRAME;
                        len_d       = 12'd0;
                        sr_cnt_d    = 3'd0;
                        crc_d       = 32'hffffffff;
                        frame_start = 1'b1;
                    end else begin
                        state_d = S_DISCARD;
                        pre_set = 1'b1;
                    end
                end
            end
            S_FRAME: begin
                if (!bus.TxEn) begin
                    state_d   = S_IDLE;
                    end_frame = 1'b1;
                    if (!st_short) begin
                        push      = 1'b1;
                        push_eof  = 1'b1;
                        push_err  = st_crc | st_runt | st_over | frame_ovf_q;
                        push_data = sr_q[0];
                    end
                end else if (accept) begin
                    len_d = (len_q == 12'hfff) ? len_q : len_q + 12'd1;
                    if (sr_cnt_q == 3'd5) begin
                        push      = (len_q < MAX_LEN);
                        push_data = sr_q[0];
                        crc_d     = crc32_byte(crc_q, sr_q[0]);
                        for (int i = 0; i < 4; i++) sr_d[i] = sr_q[i+1];
                        sr_d[4] = bus.TxD;
                    end else begin
                        sr_d[sr_cnt_q] = bus.TxD;
                        sr_cnt_d       = sr_cnt_q + 3'd1;
                    end
                end
            end
            S_DISCARD: begin
                if (!bus.TxEn) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A simultaneous pop frees the slot, so push-while-full only drops when nothing leaves.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop        = ~fifo_empty & bus.out_ready;
    assign push_ok    = push & (~fifo_full | pop);
    assign drop       = push & fifo_full & ~pop;
    assign overwrite  = drop & push_eof;
    assign tail_idx   = wr_ptr_q[FIFO_AW-1:0] - {{(FIFO_AW-1){1'b0}}, 1'b1};
    assign wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign head       = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    assign frame_ovf_d = frame_start ? 1'b0 : (frame_ovf_q | drop);
    assign pre_err_d   = pre_set | (pre_err_q & ~clearErrors_i);
    assign ovf_err_d   = drop | (ovf_err_q & ~clearErrors_i);

    always_ff @(posedge clk_i or posedge resetActive_i) begin
        if (resetActive_i) begin
            state_q      <= S_IDLE;
            pcnt_q       <= 4'd0;
            len_q        <= 12'd0;
            for (int i = 0; i < 5; i++) sr_q[i] <= 8'h00;
            sr_cnt_q     <= 3'd0;
            crc_q        <= 32'hffffffff;
            frame_ovf_q  <= 1'b0;
            pre_err_q    <= 1'b0;
            ovf_err_q    <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_len_q   <= 12'd0;
            stat_crc_q   <= 1'b0;
            stat_runt_q  <= 1'b0;
            stat_over_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            len_q        <= len_d;
            sr_q         <= sr_d;
            sr_cnt_q     <= sr_cnt_d;
            crc_q        <= crc_d;
            frame_ovf_q  <= frame_ovf_d;
            pre_err_q    <= pre_err_d;
            ovf_err_q    <= ovf_err_d;
            stat_valid_q <= end_frame;
            if (end_frame) begin
                stat_len_q  <= len_q;
                stat_crc_q  <= st_crc;
                stat_runt_q <= st_runt;
                stat_over_q <= st_over;
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // A dropped terminator re-tags the newest stored byte so the frame still ends, marked bad.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {push_eof, push_err, push_data};
        end else if (overwrite) begin
            mem_q[tail_idx] <= {2'b11, mem_q[tail_idx][7:0]};
        end
    end

    assign bus.out_valid = ~fifo_empty;
    assign bus.out_data  = fifo_empty ? 8'h00 : head[7:0];
    assign bus.out_eof   = ~fifo_empty & head[9];
    assign bus.out_err   = ~fifo_empty & head[8];

    assign stat_valid_o   = stat_valid_q;
    assign stat_len_o     = stat_len_q;
    assign stat_crc_err_o = stat_crc_q;
    assign stat_runt_o    = stat_runt_q;
    assign stat_over_o    = stat_over_q;
    assign pre_err_o      = pre_err_q;
    assign ovf_err_o      = ovf_err_q;

`ifdef ETH_TX_SINK_STATS_EN
    logic [7:0] num_frames_q, num_crc_q, num_runt_q, num_drop_q;
    logic       unused_raddr;

    always_ff @(posedge clk_i or posedge resetActive_i) begin
        if (resetActive_i) begin
            num_frames_q <= 8'd0;
            num_crc_q    <= 8'd0;
            num_runt_q   <= 8'd0;
            num_drop_q   <= 8'd0;
        end else begin
            if (end_frame)             num_frames_q <= num_frames_q + 8'd1;
            if (end_frame && st_crc)   num_crc_q    <= num_crc_q + 8'd1;
            if (end_frame && st_runt)  num_runt_q   <= num_runt_q + 8'd1;
            if (drop || pre_set)       num_drop_q   <= num_drop_q + 8'd1;
        end
    end

    assign reg_rdata_o  = (reg_raddr_i[7:4] == 4'hb) ?
                          {num_drop_q, num_runt_q, num_crc_q, num_frames_q} : 32'd0;
    assign unused_raddr = ^{reg_raddr_i[15:8], reg_raddr_i[3:0]};
`else
    logic unused_raddr;
    assign reg_rdata_o  = 32'd0;
    assign unused_raddr = ^reg_raddr_i;
`endif
endmodule

// File: tb/tb_eth_rt_tx_sink.sv
// tb/tb_eth_rt_tx_sink.sv - directed self-checking bench for eth_rt_tx_sink
// Frames are built with a reflected CRC-32 reference; FIFO pops and status pulses are logged on negedge.
module tb_eth_rt_tx_sink;
    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [15:0] raddr;
    logic        stat_valid, stat_crc_err, stat_runt, stat_over, pre_err, ovf_err;
    logic [11:0] stat_len;
    logic [31:0] rdata;

    eth_rt_tx_sink_if bus ();

    eth_rt_tx_sink #(.FIFO_AW(4), .MIN_FRAME(64), .MAX_FRAME(1518)) dut (
        .clk_i          (clk),
        .resetActive_i  (rst),
        .clearErrors_i  (clr),
        .bus            (bus),
        .stat_valid_o   (stat_valid),
        .stat_len_o     (stat_len),
        .stat_crc_err_o (stat_crc_err),
        .stat_runt_o    (stat_runt),
        .stat_over_o    (stat_over),
        .pre_err_o      (pre_err),
        .ovf_err_o      (ovf_err),
        .reg_raddr_i    (raddr),
        .reg_rdata_o    (rdata)
    );

    always #5 clk = ~clk;

    logic [9:0]  q [$];
    int          nstat = 0;
    logic [11:0] s_len = '0;
    logic        s_crc = 1'b0, s_runt = 1'b0, s_over = 1'b0;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) q.push_back({bus.out_eof, bus.out_err, bus.out_data});
        if (stat_valid) begin
            nstat  <= nstat + 1;
            s_len  <= stat_len;
            s_crc  <= stat_crc_err;
            s_runt <= stat_runt;
            s_over <= stat_over;
        end
    end

    int         total = 0;
    int         passed = 0;
    int         failed = 0;
    logic [7:0] dat [0:63];
    int         qb, sb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b, input bit toggle);
        if (toggle) begin
            @(posedge clk); #1;
            bus.TxEn = 1'b1; bus.DataReady = 1'b0; bus.TxD = 8'hd5;
        end
        @(posedge clk); #1;
        bus.TxEn = 1'b1; bus.DataReady = 1'b1; bus.TxD = b;
    endtask

    task automatic send_frame(input int nd, input int npre, input logic [7:0] seed,
                              input bit flip, input bit toggle);
        logic [31:0] c;
        for (int i = 0; i < nd; i++) dat[i] = 8'(i * 29) ^ seed;
        c = 32'hffffffff;
        for (int i = 0; i < nd; i++) begin
            c = c ^ {24'd0, dat[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        end
        c = ~c;
        if (flip) c[3] = ~c[3];
        for (int i = 0; i < npre; i++) put(8'h55, toggle);
        put(8'hd5, toggle);
        for (int i = 0; i < nd; i++) put(dat[i], toggle);
        for (int i = 0; i < 4; i++) put(c[8*i +: 8], toggle);
        @(posedge clk); #1;
        bus.TxEn = 1'b0; bus.DataReady = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int qbase, input int exp_n, input logic exp_err);
        int         bad;
        int         neof;
        logic [9:0] last;
        bad  = 0;
        neof = 0;
        chk({tag, " entries"}, q.size() - qbase, exp_n);
        for (int i = 0; i < exp_n && qbase + i < q.size(); i++) begin
            if (q[qbase+i][7:0] !== dat[i]) bad++;
            if (q[qbase+i][9]) neof++;
        end
        last = (q.size() > qbase) ? q[q.size()-1] : 10'd0;
        chk({tag, " data mismatches"}, bad, 0);
        chk({tag, " eof count"}, neof, 1);
        chk({tag, " last eof/err"}, {30'd0, last[9:8]}, {30'd0, 1'b1, exp_err});
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; raddr = 16'h00b0;
        bus.TxEn = 1'b0; bus.DataReady = 1'b0; bus.TxD = 8'h00; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_data", bus.out_data, 0);
        chk("reset stat_valid", stat_valid, 0);
        chk("reset stat_len", stat_len, 0);
        chk("reset pre_err", pre_err, 0);
        chk("reset ovf_err", ovf_err, 0);
        chk("reset reg_rdata", rdata, 0);

        // good 64-byte frame
        qb = q.size(); sb = nstat;
        send_frame(60, 7, 8'h00, 1'b0, 1'b0);
        repeat (40) @(posedge clk); #1;
        check_frame("good", qb, 60, 1'b0);
        chk("good stat count", nstat - sb, 1);
        chk("good stat_len", s_len, 64);
        chk("good crc_err", s_crc, 0);
        chk("good runt", s_runt, 0);
        chk("good over", s_over, 0);
        chk("good pre_err", pre_err, 0);
        chk("good ovf_err", ovf_err, 0);

        // one FCS bit flipped
        qb = q.size(); sb = nstat;
        send_frame(60, 7, 8'ha5, 1'b1, 1'b0);
        repeat (40) @(posedge clk); #1;
        check_frame("badfcs", qb, 60, 1'b1);
        chk("badfcs stat count", nstat - sb, 1);
        chk("badfcs crc_err", s_crc, 1);
        chk("badfcs stat_len", s_len, 64);
        chk("badfcs runt", s_runt, 0);

        // 40-byte frame with valid FCS
        qb = q.size(); sb = nstat;
        send_frame(36, 7, 8'h5a, 1'b0, 1'b0);
        repeat (40) @(posedge clk); #1;
        check_frame("runt", qb, 36, 1'b1);
        chk("runt flag", s_runt, 1);
        chk("runt crc_err", s_crc, 0);
        chk("runt stat_len", s_len, 40);

        // short preamble
        qb = q.size(); sb = nstat;
        send_frame(60, 6, 8'h11, 1'b0, 1'b0);
        repeat (10) @(posedge clk); #1;
        chk("shortpre entries", q.size() - qb, 0);
        chk("shortpre out_valid", bus.out_valid, 0);
        chk("shortpre pre_err", pre_err, 1);
        chk("shortpre stat count", nstat - sb, 0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clear pre_err", pre_err, 0);

        // overflow with no downstream pops
        bus.out_ready = 1'b0;
        qb = q.size(); sb = nstat;
        send_frame(60, 7, 8'h33, 1'b0, 1'b0);
        repeat (10) @(posedge clk); #1;
        chk("ovf out_valid", bus.out_valid, 1);
        chk("ovf ovf_err", ovf_err, 1);
        chk("ovf stat_len", s_len, 64);
        chk("ovf crc_err", s_crc, 0);
        bus.out_ready = 1'b1;
        repeat (40) @(posedge clk); #1;
        check_frame("ovf", qb, 16, 1'b1);

        // DataReady gaps
        qb = q.size(); sb = nstat;
        send_frame(60, 7, 8'h77, 1'b0, 1'b1);
        repeat (40) @(posedge clk); #1;
        check_frame("gaps", qb, 60, 1'b0);
        chk("gaps stat_len", s_len, 64);
        chk("gaps crc_err", s_crc, 0);
        chk("gaps stat count", nstat - sb, 1);

        // reset in the middle of a frame
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) put(8'h55, 1'b0);
        put(8'hd5, 1'b0);
        for (int i = 0; i < 20; i++) put(8'(i + 100), 1'b0);
        @(posedge clk); #1;
        chk("midrst fifo filled", bus.out_valid, 1);
        rst = 1'b1; bus.TxEn = 1'b0; bus.DataReady = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("midrst out_valid", bus.out_valid, 0);
        chk("midrst out_data", bus.out_data, 0);
        chk("midrst ovf_err", ovf_err, 0);
        chk("midrst stat_valid", stat_valid, 0);
        rst = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        qb = q.size(); sb = nstat;
        send_frame(60, 7, 8'hc3, 1'b0, 1'b0);
        repeat (40) @(posedge clk); #1;
        check_frame("postrst", qb, 60, 1'b0);
        chk("postrst stat_len", s_len, 64);
        chk("postrst crc_err", s_crc, 0);
        chk("reg_rdata default", rdata, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
